mp4_tag_array_nway: RTL and testbench
=====================================

# mp4_tag_array_nway

Parametrised set-associative tag store for the mp4 caches, the successor to the single-way 16x23 tag macro. It stores a tag plus valid and dirty bits per way per set, reads all ways of a set in one access, and compares them against a lookup tag to produce a registered hit and one-hot hit way. On reset it sweeps every set to clear the valid and dirty bits, so the cache controller needs no separate flush pass.

## Interface
- TAG_WIDTH, 23, tag bits per way
- SET_WIDTH, 4, set index bits; SETS = 1 << SET_WIDTH
- WAYS, 2, associativity (>= 1)

- clk0  in  1  clock; all state updates on posedge
- rst0  in  1  synchronous, active-high reset
- ready0  out  1  high when requests are accepted
- csb0  in  1  active-low chip select
- web0  in  1  active-low write enable
- wmask0  in  WAYS  per-way write enable, used only when web0=0
- addr0  in  SET_WIDTH  set index
- din_tag0  in  TAG_WIDTH  write tag
- din_valid0  in  1  write valid bit
- din_dirty0  in  1  write dirty bit
- lookup_tag0  in  TAG_WIDTH  compare tag for reads
- dout_tag0  out  WAYS*TAG_WIDTH  way w tag at [w*TAG_WIDTH +: TAG_WIDTH]
- dout_valid0  out  WAYS  per-way valid
- dout_dirty0  out  WAYS  per-way dirty
- rvalid0  out  1  read result valid
- hit0  out  1  any valid way matches lookup_tag0
- hit_way0  out  WAYS  one-hot matching way

## Operation
- States: INIT and READY. ready0 = (state == READY).
- A request is accepted at a posedge with ready0=1 and csb0=0. Otherwise the array and outputs hold, and rvalid0 goes to 0.
- Write (web0=0): for every way w with wmask0[w]=1, set[addr0].way[w] takes {din_tag0, din_valid0, din_dirty0}. Ways with wmask0=0 are unchanged. wmask0=0 is a no-op. A write drives rvalid0 to 0 and leaves dout/hit outputs unchanged.
- Read (web0=1): registers all ways of set addr0 into dout_*. It also registers the hit logic.
  - hit_way0[w] = valid[w] && tag[w] == lookup_tag0.
  - hit0 = |hit_way0.
  - If several ways match (illegal for the controller), only the lowest index is set in hit_way0.
- INIT sweep: a counter runs 0..SETS-1. Each cycle it clears valid and dirty of all ways in set counter. Tags are not cleared (X in simulation until written). After set SETS-1 is cleared, state goes to READY.
- Requests presented during INIT are ignored: no array change, rvalid0=0.

## Timing
- Reset (rst0=1 at posedge, at any point, including mid-sweep): state=INIT, counter=0, ready0=0, rvalid0=0, hit0=0, hit_way0=0, dout_tag0=0, dout_valid0=0, dout_dirty0=0.
- Sweep timing: the first posedge with rst0=0 clears set 0, and the k-th such edge clears set k-1. ready0 rises after the SETS-th edge, i.e. SETS cycles after reset deasserts.
- Reasserting rst0 during the sweep restarts it from set 0.
- Read latency is 1: request at edge N gives dout_*, hit0, hit_way0 and rvalid0=1 during cycle N..N+1.
  - rvalid0 is a 1-cycle pulse per accepted read.
  - Back-to-back reads give rvalid0 high continuously.
- A read at edge N+1 after a write to the same set at edge N returns the written data. This is the single-port ordering; no bypass is needed.
- Outputs hold their last read value until the next accepted read or a reset.

## Test plan
- Reset sweep, WAYS=2, SET_WIDTH=4:
  - pulse rst0 -> ready0=0 for exactly 16 cycles after rst0 falls, then 1.
  - A read of each set then returns dout_valid0=2'b00, dout_dirty0=2'b00, hit0=0.
- Masked write then read:
  - write set 5, wmask0=2'b10, tag 0x1ABCDE, valid=1, dirty=1.
  - Next cycle, read set 5 with lookup_tag0=0x1ABCDE -> rvalid0=1, hit0=1, hit_way0=2'b10, dout_valid0=2'b10, dout_dirty0=2'b10, way 1 tag=0x1ABCDE.
- Miss on tag and on invalid:
  - same state, lookup 0x1ABCDF -> hit0=0.
  - Write way 1 with valid=0, then lookup 0x1ABCDE -> hit0=0, hit_way0=0.
- Duplicate tag priority: write tag 0x00042 valid to both ways of set 0 -> read gives hit_way0=2'b01.
- Ignored requests:
  - csb0=1, or any request during INIT -> rvalid0=0 and array unchanged.
  - Verify by a later read of set 3 returning its previous contents.
- Reset mid-sweep: assert rst0 after 7 sweep cycles -> ready0 stays 0 for a full 16 cycles after the new deassertion.
- Parameter sweep: repeat the masked write/read scenario with WAYS=4, SET_WIDTH=6, TAG_WIDTH=20, targeting way 3 of set 63.

Source files
------------

// File: rtl/mp4_tag_array_nway.sv
// ---------------------------------------------------------------------------
// mp4_tag_array_nway
//
// Set-associative tag store for the mp4 caches. Each set holds WAYS entries of
// {tag, valid, dirty}. A read returns every way of one set plus a registered
// hit / one-hot hit-way result for lookup_tag0. After reset the block sweeps
// every set clearing valid and dirty, then raises ready0.
//
// Ports
//   clk0         clock, all state changes on posedge
//   rst0         synchronous active-high reset
//   ready0       high when requests are accepted (sweep finished)
//   csb0         active-low chip select
//   web0         active-low write enable
//   wmask0       per-way write enable (writes only)
//   addr0        set index
//   din_tag0     write tag
//   din_valid0   write valid bit
//   din_dirty0   write dirty bit
//   lookup_tag0  compare tag for reads
//   dout_tag0    way w tag at [w*TAG_WIDTH +: TAG_WIDTH]
//   dout_valid0  per-way valid of the last read set
//   dout_dirty0  per-way dirty of the last read set
//   rvalid0      one-cycle pulse per accepted read
//   hit0         some valid way matched lookup_tag0
//   hit_way0     one-hot matching way (lowest index wins)
// ---------------------------------------------------------------------------
module mp4_tag_array_nway #(
    parameter int TAG_WIDTH = 23,
    parameter int SET_WIDTH = 4,
    parameter int WAYS      = 2
) (
    input  logic                      clk0,
    input  logic                      rst0,
    output logic                      ready0,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [WAYS-1:0]           wmask0,
    input  logic [SET_WIDTH-1:0]      addr0,
    input  logic [TAG_WIDTH-1:0]      din_tag0,
    input  logic                      din_valid0,
    input  logic                      din_dirty0,
    input  logic [TAG_WIDTH-1:0]      lookup_tag0,
    output logic [WAYS*TAG_WIDTH-1:0] dout_tag0,
    output logic [WAYS-1:0]           dout_valid0,
    output logic [WAYS-1:0]           dout_dirty0,
    output logic                      rvalid0,
    output logic                      hit0,
    output logic [WAYS-1:0]           hit_way0
);

    localparam int                   SETS     = 1 << SET_WIDTH;
    localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(SETS - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [SET_WIDTH-1:0]     cnt_q, cnt_d;

    // Storage: tags are never reset, only valid/dirty are swept.
    logic [TAG_WIDTH-1:0]     tag_q   [SETS][WAYS];
    logic [TAG_WIDTH-1:0]     tag_d   [SETS][WAYS];
    logic [WAYS-1:0]          valid_q [SETS];
    logic [WAYS-1:0]          valid_d [SETS];
    logic [WAYS-1:0]          dirty_q [SETS];
    logic [WAYS-1:0]          dirty_d [SETS];

    logic [WAYS*TAG_WIDTH-1:0] dout_tag_q, dout_tag_d;
    logic [WAYS-1:0]           dout_valid_q, dout_valid_d;
    logic [WAYS-1:0]           dout_dirty_q, dout_dirty_d;
    logic                      rvalid_q, rvalid_d;
    logic                      hit_q, hit_d;
    logic [WAYS-1:0]           hit_way_q, hit_way_d;

    logic                      accept_s;
    logic                      match_found_s;

    assign accept_s = (state_q == ST_READY) && !csb0;

    // Next-state logic: sweep, writes, and read/compare capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        dout_tag_d    = dout_tag_q;
        dout_valid_d  = dout_valid_q;
        dout_dirty_d  = dout_dirty_q;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        rvalid_d      = 1'b0;
        match_found_s = 1'b0;

        if (rst0) begin
            // Array holds during reset; control and outputs reset in the flops.
            rvalid_d = 1'b0;
        end else if (state_q == ST_INIT) begin
            valid_d[cnt_q] = '0;
            dirty_d[cnt_q] = '0;
            if (cnt_q == LAST_SET) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + SET_WIDTH'(1);
            end
        end else if (accept_s) begin
            if (!web0) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (wmask0[w]) begin
                        tag_d[addr0][w]   = din_tag0;
                        valid_d[addr0][w] = din_valid0;
                        dirty_d[addr0][w] = din_dirty0;
                    end else begin
                        tag_d[addr0][w]   = tag_q[addr0][w];
                    end
                end
            end else begin
                rvalid_d     = 1'b1;
                hit_way_d    = '0;
                dout_valid_d = valid_q[addr0];
                dout_dirty_d = dirty_q[addr0];
                for (int w = 0; w < WAYS; w++) begin
                    dout_tag_d[w*TAG_WIDTH +: TAG_WIDTH] = tag_q[addr0][w];
                    // Scan upward and keep only the first match so a duplicate
                    // tag never produces a multi-hot hit_way0.
                    if (!match_found_s && valid_q[addr0][w] &&
                        (tag_q[addr0][w] == lookup_tag0)) begin
                        hit_way_d[w]  = 1'b1;
                        match_found_s = 1'b1;
                    end else begin
                        match_found_s = match_found_s;
                    end
                end
                hit_d = match_found_s;
            end
        end else begin
            rvalid_d = 1'b0;
        end
    end

    // Control state and registered outputs with synchronous reset.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            dout_tag_q   <= '0;
            dout_valid_q <= '0;
            dout_dirty_q <= '0;
            rvalid_q     <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_tag_q   <= dout_tag_d;
            dout_valid_q <= dout_valid_d;
            dout_dirty_q <= dout_dirty_d;
            rvalid_q     <= rvalid_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
        end
    end

    // Array storage; no reset here, the sweep clears valid/dirty instead.
    always_ff @(posedge clk0) begin
        tag_q   <= tag_d;
        valid_q <= valid_d;
        dirty_q <= dirty_d;
    end

    assign ready0      = (state_q == ST_READY);
    assign dout_tag0   = dout_tag_q;
    assign dout_valid0 = dout_valid_q;
    assign dout_dirty0 = dout_dirty_q;
    assign rvalid0     = rvalid_q;
    assign hit0        = hit_q;
    assign hit_way0    = hit_way_q;

endmodule

// File: tb/tb_mp4_tag_array_nway.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mp4_tag_array_nway. Instance dut uses the default
// geometry and is tracked by a behavioural model (per-set arrays of way
// records plus a "cycles since reset released" count). Instance dut4 uses
// WAYS=4, SET_WIDTH=6, TAG_WIDTH=20 and is checked with directed constants.
// ---------------------------------------------------------------------------
module tb_mp4_tag_array_nway;

    localparam int TW = 23;
    localparam int WY = 2;
    localparam int NS = 16;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Default-geometry instance
    logic            rst0, csb0, web0, din_valid0, din_dirty0;
    logic [WY-1:0]   wmask0;
    logic [3:0]      addr0;
    logic [TW-1:0]   din_tag0, lookup_tag0;
    logic            ready0, rvalid0, hit0;
    logic [WY*TW-1:0] dout_tag0;
    logic [WY-1:0]   dout_valid0, dout_dirty0, hit_way0;

    mp4_tag_array_nway dut (
        .clk0(clk0), .rst0(rst0), .ready0(ready0), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din_tag0(din_tag0),
        .din_valid0(din_valid0), .din_dirty0(din_dirty0),
        .lookup_tag0(lookup_tag0), .dout_tag0(dout_tag0),
        .dout_valid0(dout_valid0), .dout_dirty0(dout_dirty0),
        .rvalid0(rvalid0), .hit0(hit0), .hit_way0(hit_way0)
    );

    // Wide instance
    logic            b_rst, b_csb, b_web, b_dv_in, b_dd_in;
    logic [3:0]      b_wmask;
    logic [5:0]      b_addr;
    logic [19:0]     b_tag_in, b_lookup;
    logic            b_ready, b_rvalid, b_hit;
    logic [79:0]     b_dout_tag;
    logic [3:0]      b_dout_valid, b_dout_dirty, b_hit_way;

    mp4_tag_array_nway #(.TAG_WIDTH(20), .SET_WIDTH(6), .WAYS(4)) dut4 (
        .clk0(clk0), .rst0(b_rst), .ready0(b_ready), .csb0(b_csb), .web0(b_web),
        .wmask0(b_wmask), .addr0(b_addr), .din_tag0(b_tag_in),
        .din_valid0(b_dv_in), .din_dirty0(b_dd_in),
        .lookup_tag0(b_lookup), .dout_tag0(b_dout_tag),
        .dout_valid0(b_dout_valid), .dout_dirty0(b_dout_dirty),
        .rvalid0(b_rvalid), .hit0(b_hit), .hit_way0(b_hit_way)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [TW-1:0] m_tag   [NS][WY];
    bit            m_known [NS][WY];
    bit            m_valid [NS][WY];
    bit            m_dirty [NS][WY];
    int            m_since = 0;
    bit            e_ready = 1'b0, e_rvalid = 1'b0, e_hit = 1'b0;
    bit [WY-1:0]   e_hway = '0, e_dv = '0, e_dd = '0;
    logic [TW-1:0] e_tag [WY];
    bit            e_tk  [WY];

    logic [TW-1:0] tpool [4];

    task automatic model_edge(input logic rst, input logic csb, input logic web,
                              input logic [WY-1:0] wm, input logic [3:0] a,
                              input logic [TW-1:0] t, input logic v, input logic d,
                              input logic [TW-1:0] lk);
        int mq[$];
        if (rst) begin
            m_since = 0; e_rvalid = 1'b0; e_hit = 1'b0;
            e_hway = '0; e_dv = '0; e_dd = '0;
            for (int w = 0; w < WY; w++) begin e_tag[w] = '0; e_tk[w] = 1'b1; end
        end else if (m_since < NS) begin
            for (int w = 0; w < WY; w++) begin
                m_valid[m_since][w] = 1'b0; m_dirty[m_since][w] = 1'b0;
            end
            m_since++;
            e_rvalid = 1'b0;
        end else if (!csb && !web) begin
            for (int w = 0; w < WY; w++) begin
                if (wm[w]) begin
                    m_tag[a][w] = t; m_known[a][w] = 1'b1;
                    m_valid[a][w] = v; m_dirty[a][w] = d;
                end
            end
            e_rvalid = 1'b0;
        end else if (!csb) begin
            e_rvalid = 1'b1;
            for (int w = 0; w < WY; w++) begin
                e_tag[w] = m_tag[a][w]; e_tk[w] = m_known[a][w];
                e_dv[w] = m_valid[a][w]; e_dd[w] = m_dirty[a][w];
                if (m_valid[a][w] && m_tag[a][w] == lk) mq.push_back(w);
            end
            e_hit  = (mq.size() > 0);
            e_hway = '0;
            if (mq.size() > 0) e_hway[mq[0]] = 1'b1;
        end else begin
            e_rvalid = 1'b0;
        end
        e_ready = (m_since >= NS);
    endtask

    task automatic cyc(input logic rst, input logic csb, input logic web,
                       input logic [WY-1:0] wm, input logic [3:0] a,
                       input logic [TW-1:0] t, input logic v, input logic d,
                       input logic [TW-1:0] lk);
        rst0 = rst; csb0 = csb; web0 = web; wmask0 = wm; addr0 = a;
        din_tag0 = t; din_valid0 = v; din_dirty0 = d; lookup_tag0 = lk;
        model_edge(rst, csb, web, wm, a, t, v, d, lk);
        @(posedge clk0);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [WY-1:0] wm,
                      input logic [TW-1:0] t, input logic v, input logic d);
        cyc(1'b0, 1'b0, 1'b0, wm, a, t, v, d, TW'($urandom));
    endtask

    task automatic rd(input logic [3:0] a, input logic [TW-1:0] lk);
        cyc(1'b0, 1'b0, 1'b1, 2'($urandom), a, TW'($urandom), 1'($urandom), 1'($urandom), lk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'($urandom), 2'($urandom), 4'($urandom), TW'($urandom), 1'b1, 1'b1, TW'($urandom));
    endtask

    task automatic test_reset();
        int rdy_at;
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, '0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, '0, 1'b0, 1'b0, '0);
        n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", ready0); end
        n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b exp 0", rvalid0); end
        n_vec++; if (hit0 !== 1'b0 || hit_way0 !== 2'b00) begin n_err++; $display("FAIL reset_hit got %b/%b exp 0/00", hit0, hit_way0); end
        n_vec++; if (dout_tag0 !== '0 || dout_valid0 !== 2'b00 || dout_dirty0 !== 2'b00) begin
            n_err++; $display("FAIL reset_dout got %h/%b/%b exp 0", dout_tag0, dout_valid0, dout_dirty0); end
        rdy_at = -1;
        for (int k = 1; k <= 40; k++) begin
            idle();
            n_vec++; if (ready0 !== e_ready) begin n_err++; $display("FAIL sweep_ready k=%0d got %b exp %b", k, ready0, e_ready); end
            if (ready0 === 1'b1) begin rdy_at = k; break; end
        end
        n_vec++; if (rdy_at != NS) begin n_err++; $display("FAIL sweep_len got %0d exp %0d", rdy_at, NS); end
        for (int s = 0; s < NS; s++) begin
            rd(4'(s), TW'($urandom));
            n_vec++; if (rvalid0 !== 1'b1 || dout_valid0 !== 2'b00 || dout_dirty0 !== 2'b00 || hit0 !== 1'b0) begin
                n_err++; $display("FAIL swept_set %0d got rv=%b v=%b d=%b h=%b exp 1/00/00/0", s, rvalid0, dout_valid0, dout_dirty0, hit0); end
        end
    endtask

    task automatic test_masked_write();
        wr(4'd5, 2'b10, 23'h1ABCDE, 1'b1, 1'b1);
        n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL mw_write_rvalid got %b exp 0", rvalid0); end
        rd(4'd5, 23'h1ABCDE);
        n_vec++; if (rvalid0 !== 1'b1 || hit0 !== 1'b1) begin n_err++; $display("FAIL mw_hit got rv=%b h=%b exp 1/1", rvalid0, hit0); end
        n_vec++; if (hit_way0 !== 2'b10) begin n_err++; $display("FAIL mw_hit_way got %b exp 10", hit_way0); end
        n_vec++; if (dout_valid0 !== 2'b10 || dout_dirty0 !== 2'b10) begin n_err++; $display("FAIL mw_vd got %b/%b exp 10/10", dout_valid0, dout_dirty0); end
        n_vec++; if (dout_tag0[45:23] !== 23'h1ABCDE) begin n_err++; $display("FAIL mw_tag got %h exp 1abcde", dout_tag0[45:23]); end
    endtask

    task automatic test_miss();
        rd(4'd5, 23'h1ABCDF);
        n_vec++; if (rvalid0 !== 1'b1 || hit0 !== 1'b0 || hit_way0 !== 2'b00) begin
            n_err++; $display("FAIL miss_tag got rv=%b h=%b hw=%b exp 1/0/00", rvalid0, hit0, hit_way0); end
        wr(4'd5, 2'b10, 23'h1ABCDE, 1'b0, 1'b0);
        rd(4'd5, 23'h1ABCDE);
        n_vec++; if (hit0 !== 1'b0 || hit_way0 !== 2'b00 || dout_valid0 !== 2'b00) begin
            n_err++; $display("FAIL miss_invalid got h=%b hw=%b v=%b exp 0/00/00", hit0, hit_way0, dout_valid0); end
    endtask

    task automatic test_dup_priority();
        wr(4'd0, 2'b11, 23'h000042, 1'b1, 1'b0);
        rd(4'd0, 23'h000042);
        n_vec++; if (hit0 !== 1'b1 || hit_way0 !== 2'b01 || dout_valid0 !== 2'b11) begin
            n_err++; $display("FAIL dup_prio got h=%b hw=%b v=%b exp 1/01/11", hit0, hit_way0, dout_valid0); end
    endtask

    task automatic test_ignored();
        wr(4'd3, 2'b11, 23'h0333AA, 1'b1, 1'b1);
        rd(4'd3, 23'h0333AA);
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 4'd3, 23'h7FFFFF, 1'b0, 1'b0, 23'h7FFFFF);
        n_vec++; if (rvalid0 !== 1'b0 || hit0 !== 1'b1 || hit_way0 !== 2'b01 || dout_tag0[22:0] !== 23'h0333AA) begin
            n_err++; $display("FAIL csb_hold got rv=%b h=%b hw=%b t=%h exp 0/1/01/0333aa", rvalid0, hit0, hit_way0, dout_tag0[22:0]); end
        cyc(1'b0, 1'b1, 1'b1, 2'b00, 4'd3, '0, 1'b0, 1'b0, 23'h0333AA);
        n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL csb_read_rvalid got %b exp 0", rvalid0); end
        rd(4'd3, 23'h0333AA);
        n_vec++; if (dout_valid0 !== 2'b11 || dout_dirty0 !== 2'b11 || dout_tag0[45:23] !== 23'h0333AA) begin
            n_err++; $display("FAIL csb_array got v=%b d=%b t1=%h exp 11/11/0333aa", dout_valid0, dout_dirty0, dout_tag0[45:23]); end
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, '0, 1'b0, 1'b0, '0);
        for (int k = 0; k < NS; k++) begin
            if (k[0]) wr(4'd3, 2'b11, 23'h155555, 1'b1, 1'b1);
            else      rd(4'd3, 23'h155555);
            n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL init_ignore k=%0d rvalid got %b exp 0", k, rvalid0); end
        end
        n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL init_ready got %b exp 1", ready0); end
        rd(4'd3, 23'h0333AA);
        n_vec++; if (rvalid0 !== 1'b1 || dout_valid0 !== 2'b00 || hit0 !== 1'b0 ||
                     dout_tag0 !== {23'h0333AA, 23'h0333AA}) begin
            n_err++; $display("FAIL init_array got rv=%b v=%b h=%b t=%h exp 1/00/0/0333aa x2", rvalid0, dout_valid0, hit0, dout_tag0); end
    endtask

    task automatic test_reset_midsweep();
        int rdy_at;
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, '0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 7; k++) begin
            idle();
            n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL midsweep_early k=%0d got %b exp 0", k, ready0); end
        end
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, '0, 1'b0, 1'b0, '0);
        rdy_at = -1;
        for (int k = 1; k <= 40; k++) begin
            idle();
            if (ready0 === 1'b1) begin rdy_at = k; break; end
        end
        n_vec++; if (rdy_at != NS) begin n_err++; $display("FAIL midsweep_len got %0d exp %0d", rdy_at, NS); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            rd(4'($urandom_range(0, 15)), tpool[$urandom_range(0, 3)]);
            n_vec++; if (rvalid0 !== 1'b1 || hit0 !== e_hit || hit_way0 !== e_hway || dout_valid0 !== e_dv) begin
                n_err++; $display("FAIL b2b k=%0d got rv=%b h=%b hw=%b v=%b exp 1/%b/%b/%b", k, rvalid0, hit0, hit_way0, dout_valid0, e_hit, e_hway, e_dv); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
                2'($urandom), 4'($urandom_range(0, 15)), tpool[$urandom_range(0, 3)],
                1'($urandom_range(0, 3) != 0), 1'($urandom), tpool[$urandom_range(0, 3)]);
            n_vec++;
            if (ready0 !== e_ready || rvalid0 !== e_rvalid || hit0 !== e_hit || hit_way0 !== e_hway ||
                dout_valid0 !== e_dv || dout_dirty0 !== e_dd ||
                (e_tk[0] && dout_tag0[22:0] !== e_tag[0]) || (e_tk[1] && dout_tag0[45:23] !== e_tag[1])) begin
                n_err++;
                $display("FAIL random k=%0d got rdy=%b rv=%b h=%b hw=%b v=%b d=%b t=%h exp %b/%b/%b/%b/%b/%b/%h_%h",
                         k, ready0, rvalid0, hit0, hit_way0, dout_valid0, dout_dirty0, dout_tag0,
                         e_ready, e_rvalid, e_hit, e_hway, e_dv, e_dd, e_tag[1], e_tag[0]);
            end
        end
    endtask

    task automatic b_cyc(input logic rst, input logic csb, input logic web, input logic [3:0] wm,
                         input logic [5:0] a, input logic [19:0] t, input logic [19:0] lk);
        b_rst = rst; b_csb = csb; b_web = web; b_wmask = wm; b_addr = a;
        b_tag_in = t; b_dv_in = 1'b1; b_dd_in = 1'b1; b_lookup = lk;
        @(posedge clk0);
        #1;
    endtask

    task automatic test_param_sweep();
        int rdy_at;
        csb0 = 1'b1;
        b_cyc(1'b1, 1'b1, 1'b1, 4'h0, 6'd0, '0, '0);
        n_vec++; if (b_ready !== 1'b0 || b_dout_valid !== 4'h0) begin n_err++; $display("FAIL w4_reset got r=%b v=%b exp 0/0000", b_ready, b_dout_valid); end
        rdy_at = -1;
        for (int k = 1; k <= 200; k++) begin
            b_cyc(1'b0, 1'b1, 1'b1, 4'h0, 6'd0, '0, '0);
            if (b_ready === 1'b1) begin rdy_at = k; break; end
        end
        n_vec++; if (rdy_at != 64) begin n_err++; $display("FAIL w4_sweep_len got %0d exp 64", rdy_at); end
        b_cyc(1'b0, 1'b0, 1'b0, 4'b1000, 6'd63, 20'hABCDE, '0);
        b_cyc(1'b0, 1'b0, 1'b1, 4'b0000, 6'd63, '0, 20'hABCDE);
        n_vec++; if (b_rvalid !== 1'b1 || b_hit !== 1'b1 || b_hit_way !== 4'b1000) begin
            n_err++; $display("FAIL w4_hit got rv=%b h=%b hw=%b exp 1/1/1000", b_rvalid, b_hit, b_hit_way); end
        n_vec++; if (b_dout_valid !== 4'b1000 || b_dout_dirty !== 4'b1000 || b_dout_tag[79:60] !== 20'hABCDE) begin
            n_err++; $display("FAIL w4_data got v=%b d=%b t3=%h exp 1000/1000/abcde", b_dout_valid, b_dout_dirty, b_dout_tag[79:60]); end
        b_cyc(1'b0, 1'b0, 1'b1, 4'b0000, 6'd63, '0, 20'hABCDF);
        n_vec++; if (b_hit !== 1'b0 || b_hit_way !== 4'b0000) begin n_err++; $display("FAIL w4_miss got h=%b hw=%b exp 0/0000", b_hit, b_hit_way); end
    endtask

    initial begin
        tpool[0] = 23'h1ABCDE; tpool[1] = 23'h000042; tpool[2] = 23'h7FFFFF; tpool[3] = 23'h0333AA;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WY; w++) begin
                m_tag[s][w] = '0; m_known[s][w] = 1'b0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
            end
        for (int w = 0; w < WY; w++) begin e_tag[w] = '0; e_tk[w] = 1'b0; end
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0;
        din_tag0 = '0; din_valid0 = 1'b0; din_dirty0 = 1'b0; lookup_tag0 = '0;
        b_rst = 1'b1; b_csb = 1'b1; b_web = 1'b1; b_wmask = '0; b_addr = '0;
        b_tag_in = '0; b_dv_in = 1'b0; b_dd_in = 1'b0; b_lookup = '0;
        #2;
        test_reset();
        test_masked_write();
        test_miss();
        test_dup_priority();
        test_ignored();
        test_reset_midsweep();
        test_back_to_back();
        test_random();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
